// File: rtl/if_id_hazard_ctrl.sv
// Fetch/decode pipeline control: resolves load-use hazards, EX mispredictions and
// instruction-memory wait states, and keeps saturating stall/flush statistics.
module if_id_hazard_ctrl #(
    parameter int CNT_W         = 16,
    parameter int MAX_IMEM_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead_ID_EX,
    input  logic [4:0]       rd_ID_EX,
    input  logic [4:0]       rs_IF_ID,
    input  logic [4:0]       rt_IF_ID,
    input  logic             usesRt_IF_ID,
    input  logic             branch_EX,
    input  logic             taken_EX,
    input  logic             prediction_EX,
    input  logic             imemReady,
    output logic             pcWr,
    output logic             ifidWr,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             redirect,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount,
    output logic             imemTimeout
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        WAIT_IMEM = 2'd2
    } state_e;

    // Response selected this cycle; outputs and counter updates decode from it.
    typedef enum logic [2:0] {
        R_IDLE,
        R_NORMAL,
        R_MP,
        R_HZ,
        R_WAIT
    } resp_e;

    localparam logic [7:0] MAX_WAIT = 8'(MAX_IMEM_WAIT);

    state_e     state, state_nxt;
    resp_e      resp;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       mp;
    logic       hz;

    assign mp = branch_EX & (taken_EX != prediction_EX);
    assign hz = memRead_ID_EX & (rd_ID_EX != 5'd0) &
                ((rd_ID_EX == rs_IF_ID) | (usesRt_IF_ID & (rd_ID_EX == rt_IF_ID)));

    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        resp      = R_IDLE;
        state_nxt = RUN;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (mp)              resp = R_MP;
                    else if (hz)         resp = R_HZ;
                    else if (!imemReady) resp = R_WAIT;
                    else                 resp = R_NORMAL;
                end
                LU_STALL, WAIT_IMEM: begin
                    if (mp)              resp = R_MP;
                    else if (!imemReady) resp = R_WAIT;
                    else                 resp = R_NORMAL;
                end
                default: resp = R_IDLE;
            endcase
            case (resp)
                R_HZ:    state_nxt = LU_STALL;
                R_WAIT:  state_nxt = WAIT_IMEM;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        pcWr       = 1'b0;
        ifidWr     = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        redirect   = 1'b0;
        case (resp)
            R_NORMAL: begin
                pcWr   = 1'b1;
                ifidWr = 1'b1;
            end
            R_MP: begin
                pcWr       = 1'b1;
                ifidWr     = 1'b1;
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
                redirect   = 1'b1;
            end
            R_HZ: idexBubble = 1'b1;
            R_WAIT: begin
                ifidWr    = 1'b1;
                ifidFlush = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state and counters use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            stallCycles <= '0;
            flushCount  <= '0;
            wait_cnt    <= '0;
            imemTimeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((resp == R_HZ || resp == R_WAIT) && !(&stallCycles))
                stallCycles <= stallCycles + 1'b1;
            if (resp == R_MP && !(&flushCount))
                flushCount <= flushCount + 1'b1;
            // Wait counter only lives across consecutive not-ready cycles.
            if (resp == R_WAIT) begin
                wait_cnt <= wait_cnt_inc;
                if (wait_cnt_inc >= MAX_WAIT)
                    imemTimeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed self-checking bench for if_id_hazard_ctrl (CNT_W=4 to reach saturation).
module tb_if_id_hazard_ctrl;

    localparam int CNT_W = 4;

    // ctrl = {pcWr, ifidWr, ifidFlush, idexBubble, redirect}
    localparam logic [31:0] C_OFF  = 32'b00000;
    localparam logic [31:0] C_NORM = 32'b11000;
    localparam logic [31:0] C_MP   = 32'b11111;
    localparam logic [31:0] C_HZ   = 32'b00010;
    localparam logic [31:0] C_WAIT = 32'b01100;

    logic             clk;
    logic             reset;
    logic             memRead_ID_EX;
    logic [4:0]       rd_ID_EX;
    logic [4:0]       rs_IF_ID;
    logic [4:0]       rt_IF_ID;
    logic             usesRt_IF_ID;
    logic             branch_EX;
    logic             taken_EX;
    logic             prediction_EX;
    logic             imemReady;
    logic             pcWr;
    logic             ifidWr;
    logic             ifidFlush;
    logic             idexBubble;
    logic             redirect;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;
    logic             imemTimeout;
    logic [4:0]       ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_hazard_ctrl #(.CNT_W(CNT_W), .MAX_IMEM_WAIT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .memRead_ID_EX (memRead_ID_EX),
        .rd_ID_EX      (rd_ID_EX),
        .rs_IF_ID      (rs_IF_ID),
        .rt_IF_ID      (rt_IF_ID),
        .usesRt_IF_ID  (usesRt_IF_ID),
        .branch_EX     (branch_EX),
        .taken_EX      (taken_EX),
        .prediction_EX (prediction_EX),
        .imemReady     (imemReady),
        .pcWr          (pcWr),
        .ifidWr        (ifidWr),
        .ifidFlush     (ifidFlush),
        .idexBubble    (idexBubble),
        .redirect      (redirect),
        .stallCycles   (stallCycles),
        .flushCount    (flushCount),
        .imemTimeout   (imemTimeout)
    );

    assign ctrl = {pcWr, ifidWr, ifidFlush, idexBubble, redirect};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_idle();
        memRead_ID_EX = 1'b0;
        rd_ID_EX      = 5'd0;
        rs_IF_ID      = 5'd0;
        rt_IF_ID      = 5'd0;
        usesRt_IF_ID  = 1'b0;
        branch_EX     = 1'b0;
        taken_EX      = 1'b0;
        prediction_EX = 1'b0;
        imemReady     = 1'b1;
    endtask

    task automatic set_hz();
        memRead_ID_EX = 1'b1;
        rd_ID_EX      = 5'd5;
        rs_IF_ID      = 5'd5;
    endtask

    task automatic set_mp();
        branch_EX     = 1'b1;
        taken_EX      = 1'b1;
        prediction_EX = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with every input high.
        reset         = 1'b1;
        memRead_ID_EX = 1'b1;
        rd_ID_EX      = 5'h1F;
        rs_IF_ID      = 5'h1F;
        rt_IF_ID      = 5'h1F;
        usesRt_IF_ID  = 1'b1;
        branch_EX     = 1'b1;
        taken_EX      = 1'b1;
        prediction_EX = 1'b1;
        imemReady     = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("reset_ctrl", 32'(ctrl), C_OFF);
            tick();
        end
        check("reset_stall", 32'(stallCycles), 32'd0);
        check("reset_flush", 32'(flushCount), 32'd0);
        check("reset_tmo", 32'(imemTimeout), 32'd0);

        reset = 1'b0;
        set_idle();
        settle();
        check("first_run", 32'(ctrl), C_NORM);
        tick();

        // Load-use on rs: one stall, then normal.
        set_hz();
        settle();
        check("lu_stall", 32'(ctrl), C_HZ);
        tick();
        settle();
        check("lu_after", 32'(ctrl), C_NORM);
        check("lu_count", 32'(stallCycles), 32'd1);
        tick();

        // rd=0 never stalls.
        set_idle();
        memRead_ID_EX = 1'b1;
        settle();
        check("lu_rd0", 32'(ctrl), C_NORM);
        tick();

        // rt match ignored when rt is not read, honoured when it is.
        memRead_ID_EX = 1'b1;
        rd_ID_EX      = 5'd7;
        rs_IF_ID      = 5'd3;
        rt_IF_ID      = 5'd7;
        settle();
        check("lu_rt_unused", 32'(ctrl), C_NORM);
        tick();
        usesRt_IF_ID = 1'b1;
        settle();
        check("lu_rt_used", 32'(ctrl), C_HZ);
        tick();
        set_idle();
        settle();
        check("lu_rt_count", 32'(stallCycles), 32'd2);
        tick();

        // hz beats !imemReady in RUN; the wait is served from LU_STALL.
        set_hz();
        imemReady = 1'b0;
        settle();
        check("hz_over_wait", 32'(ctrl), C_HZ);
        tick();
        settle();
        check("lu_then_wait", 32'(ctrl), C_WAIT);
        tick();
        set_idle();
        settle();
        check("wait_release", 32'(ctrl), C_NORM);
        check("hz_wait_count", 32'(stallCycles), 32'd4);
        tick();

        // Mispredict with simultaneous hz: mp wins, no stall counted.
        set_hz();
        set_mp();
        settle();
        check("mp_ctrl", 32'(ctrl), C_MP);
        tick();
        check("mp_flush", 32'(flushCount), 32'd1);
        check("mp_stall", 32'(stallCycles), 32'd4);
        set_idle();
        branch_EX     = 1'b1;
        taken_EX      = 1'b1;
        prediction_EX = 1'b1;
        settle();
        check("br_correct", 32'(ctrl), C_NORM);
        tick();
        check("br_correct_flush", 32'(flushCount), 32'd1);

        // Three wait cycles then ready.
        set_idle();
        imemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("wait3_ctrl", 32'(ctrl), C_WAIT);
            tick();
        end
        imemReady = 1'b1;
        settle();
        check("wait3_release", 32'(ctrl), C_NORM);
        check("wait3_stall", 32'(stallCycles), 32'd7);
        tick();
        check("wait3_tmo", 32'(imemTimeout), 32'd0);
        memRead_ID_EX = 1'b1;
        rd_ID_EX      = 5'd9;
        rs_IF_ID      = 5'd9;
        settle();
        check("wait3_back_run", 32'(ctrl), C_HZ);
        tick();
        set_idle();
        tick();

        // Twenty not-ready cycles: flag rises on the 15th edge and sticks.
        imemReady = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            settle();
            check("tmo_ctrl", 32'(ctrl), C_WAIT);
            tick();
            check("tmo_flag", 32'(imemTimeout), (k >= 15) ? 32'd1 : 32'd0);
        end
        imemReady = 1'b1;
        settle();
        check("tmo_release", 32'(ctrl), C_NORM);
        tick();
        check("tmo_sticky", 32'(imemTimeout), 32'd1);
        check("stall_sat_wait", 32'(stallCycles), 32'd15);

        // Reset asserted mid-wait takes effect on that edge.
        imemReady = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        check("reset_mid_ctrl", 32'(ctrl), C_OFF);
        tick();
        reset = 1'b0;
        imemReady = 1'b1;
        settle();
        check("reset_mid_tmo", 32'(imemTimeout), 32'd0);
        check("reset_mid_stall", 32'(stallCycles), 32'd0);
        check("reset_mid_run", 32'(ctrl), C_NORM);
        tick();

        // Twenty load-use stalls saturate the 4-bit counter at 15.
        for (int i = 1; i <= 20; i++) begin
            set_hz();
            settle();
            check("sat_hz", 32'(ctrl), C_HZ);
            tick();
            set_idle();
            settle();
            check("sat_after", 32'(ctrl), C_NORM);
            tick();
            check("sat_count", 32'(stallCycles), (i < 15) ? 32'(i) : 32'd15);
        end

        // Mispredict during WAIT_IMEM aborts the wait and clears the wait counter.
        imemReady = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        set_mp();
        settle();
        check("mp_in_wait", 32'(ctrl), C_MP);
        tick();
        check("mp_in_wait_flush", 32'(flushCount), 32'd1);
        set_idle();
        set_hz();
        settle();
        check("mp_wait_to_run", 32'(ctrl), C_HZ);
        tick();
        set_idle();
        tick();
        imemReady = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("wait_cnt_cleared", 32'(imemTimeout), 32'd0);
        imemReady = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
